xor_reduce_r: RTL and testbench



---
 rtl/xor_reduce_r_pkg.sv | 12 +
 rtl/xor6_leaf.sv | 14 +
 rtl/xor_reduce_r.sv | 36 +++
 tb/tb_xor_reduce_r.sv | 94 +++++++++
 4 files changed

// File: rtl/xor_reduce_r_pkg.sv
// xor_reduce_r_pkg: shared parity/FEC constants and leaf-count helper
package xor_reduce_r_pkg;
  localparam int LEAF_SIZE = 6;
  localparam int MAX_XOR_WIDTH = 36;
  localparam int CHIP_GENERIC = 0;
  localparam int CHIP_LUT4 = 1;
  localparam int CHIP_LUT6 = 2;
  localparam int CHIP_MAX = 2;
  function automatic int num_leaves(input int width);
    return (width + LEAF_SIZE - 1) / LEAF_SIZE;
  endfunction
endpackage

// File: rtl/xor6_leaf.sv
// xor6_leaf: combinational 6-input parity, one LUT on six-input devices
module xor6_leaf
  import xor_reduce_r_pkg::*;
#(
  parameter int TARGET_CHIP = CHIP_LUT6
) (
  input  logic [LEAF_SIZE-1:0] d_i,
  output logic                 q_o
);
  if (TARGET_CHIP < CHIP_GENERIC || TARGET_CHIP > CHIP_MAX) begin : g_bad_chip
    $fatal(1, "xor6_leaf: unsupported TARGET_CHIP %0d", TARGET_CHIP);
  end
  assign q_o = ^d_i;
endmodule

// File: rtl/xor_reduce_r.sv
// xor_reduce_r: registered parity of din, one leaf per 6-bit slice feeding a single flop
module xor_reduce_r
  import xor_reduce_r_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int TARGET_CHIP = CHIP_LUT6
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);
  if (WIDTH < 1 || WIDTH > MAX_XOR_WIDTH) begin : g_bad_width
    $fatal(1, "xor_reduce_r: WIDTH %0d outside 1..%0d", WIDTH, MAX_XOR_WIDTH);
  end
  localparam int NL = num_leaves(WIDTH);
  localparam int PW = NL * LEAF_SIZE;
  logic [PW-1:0] din_pad;
  logic [NL-1:0] leaf_x;
  logic          dout_d;
  logic          dout_q = 1'b0;
  // zero padding leaves parity unchanged
  assign din_pad = PW'(din);
  for (genvar g = 0; g < NL; g++) begin : g_leaf
    xor6_leaf #(.TARGET_CHIP(TARGET_CHIP)) u_leaf (
      .d_i(din_pad[g*LEAF_SIZE +: LEAF_SIZE]),
      .q_o(leaf_x[g])
    );
  end
  assign dout_d = ^leaf_x;
  always_ff @(posedge clk) begin
    if (sclr) dout_q <= 1'b0;
    else      dout_q <= dout_d;
  end
  assign dout = dout_q;
endmodule

// File: tb/tb_xor_reduce_r.sv
// tb_xor_reduce_r: scoreboard bench running six widths side by side on one clock and reset
module tb_xor_reduce_r;
  logic        clk = 1'b0;
  logic        sclr = 1'b1;
  logic [0:0]  din1 = '0;
  logic [3:0]  din4 = '0;
  logic [4:0]  din5 = '1;
  logic [5:0]  din6 = '0;
  logic [12:0] din13 = '0;
  logic [35:0] din36 = '0;
  logic dout1, dout4, dout5, dout6, dout13, dout36;
  int checks = 0;
  int failures = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  xor_reduce_r #(.WIDTH(1))  u_w1  (.clk(clk), .sclr(sclr), .din(din1),  .dout(dout1));
  xor_reduce_r #(.WIDTH(4))  u_w4  (.clk(clk), .sclr(sclr), .din(din4),  .dout(dout4));
  xor_reduce_r #(.WIDTH(5))  u_w5  (.clk(clk), .sclr(sclr), .din(din5),  .dout(dout5));
  xor_reduce_r #(.WIDTH(6))  u_w6  (.clk(clk), .sclr(sclr), .din(din6),  .dout(dout6));
  xor_reduce_r #(.WIDTH(13)) u_w13 (.clk(clk), .sclr(sclr), .din(din13), .dout(dout13));
  xor_reduce_r #(.WIDTH(36)) u_w36 (.clk(clk), .sclr(sclr), .din(din36), .dout(dout36));

  task automatic check(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: dout=%b expected=%b at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic par(input logic [35:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic tick();
    logic [5:0] e;
    sb.push_back(sclr ? 6'b0 : {par(din36), par(36'(din13)), par(36'(din6)),
                                par(36'(din5)), par(36'(din4)), par(36'(din1))});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("w1", dout1, e[0]);
    check("w4", dout4, e[1]);
    check("w5", dout5, e[2]);
    check("w6", dout6, e[3]);
    check("w13", dout13, e[4]);
    check("w36", dout36, e[5]);
  endtask

  initial begin
    #1;
    check("pwrup_w5", dout5, 1'b0);
    check("pwrup_w36", dout36, 1'b0);
    repeat (3) tick();
    sclr = 1'b0;
    tick();
    check("rel_w5", dout5, 1'b1);
    din6 = 6'b000001; tick();
    din6 = 6'b000011; tick();
    din6 = 6'b101011; tick();
    check("lat_w6", dout6, 1'b0);
    for (int i = 0; i < 64; i++) begin
      din6 = 6'(i);
      din1 = 1'($urandom);
      din4 = 4'($urandom);
      din5 = 5'($urandom);
      din13 = 13'($urandom);
      din36 = {4'($urandom), 32'($urandom)};
      tick();
    end
    din13 = 13'h1000; tick();
    din13 = 13'h1FFF; tick();
    din13 = 13'h0FFF; tick();
    din4 = 4'b0111;
    repeat (3) tick();
    sclr = 1'b1; tick();
    check("mid_rst_w4", dout4, 1'b0);
    sclr = 1'b0; tick();
    check("mid_rel_w4", dout4, 1'b1);
    repeat (2) tick();
    din1 = 1'b0; tick();
    din1 = 1'b1; tick();
    din1 = 1'b1; tick();
    din1 = 1'b0; tick();
    din36 = 36'h8_0000_0001; tick();
    check("w36_two", dout36, 1'b0);
    din36 = 36'h8_0000_0000; tick();
    check("w36_msb", dout36, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
